lsu_wb_master: RTL

LSU_WB_MASTER -- requirements
Module: lsu_wb_master

---
 rtl/lsu_wb_master.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_wb_master.sv
// rtl/lsu_wb_master.sv - load/store unit to Wishbone classic master bridge
module lsu_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    output logic [3:0]  wb_sel,
    output logic [31:0] wb_adr,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WRITE     = 2'd1;
    localparam logic [1:0] READ_WAIT = 2'd2;
    localparam logic [1:0] RESP      = 2'd3;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [1:0]  state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [15:0] cnt_q, cnt_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        misaligned;
    logic [3:0]  sel_calc;
    logic [31:0] load_ext;
    logic [15:0] cnt_next;

    // Alignment check and byte-lane select for the incoming request
    always_comb begin
        misaligned = 1'b0;
        sel_calc   = 4'b0000;
        case (req_size)
            2'b00: sel_calc = 4'b0001 << req_addr[1:0];
            2'b01: begin
                misaligned = req_addr[0];
                sel_calc   = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                misaligned = (req_addr[1:0] != 2'b00);
                sel_calc   = 4'b1111;
            end
            default: misaligned = 1'b1;
        endcase
    end

    // Sign/zero extension of the right-aligned read data
    always_comb begin
        load_ext = wb_dat_i;
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & wb_dat_i[7]}}, wb_dat_i[7:0]};
            2'b01:   load_ext = {{16{~uns_q & wb_dat_i[15]}}, wb_dat_i[15:0]};
            default: load_ext = wb_dat_i;
        endcase
    end

    assign cnt_next = cnt_q + 16'd1;

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        uns_d        = uns_q;
        cnt_d        = cnt_q;
        cyc_d        = cyc_q;
        we_d         = we_q;
        sel_d        = sel_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    cnt_d  = 16'd0;
                    if (misaligned) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d = req_we ? WRITE : READ_WAIT;
                        cyc_d   = 1'b1;
                        we_d    = req_we;
                        sel_d   = sel_calc;
                        adr_d   = req_addr;
                        dat_d   = req_we ? req_wdata : 32'd0;
                    end
                end
            end
            WRITE: begin
                // Stores are posted: the single strobe cycle completes them
                state_d      = RESP;
                cyc_d        = 1'b0;
                we_d         = 1'b0;
                sel_d        = 4'd0;
                adr_d        = 32'd0;
                dat_d        = 32'd0;
                resp_valid_d = 1'b1;
            end
            READ_WAIT: begin
                if (wb_ack || (cnt_next == TIMEOUT_LIMIT)) begin
                    state_d      = RESP;
                    cyc_d        = 1'b0;
                    sel_d        = 4'd0;
                    adr_d        = 32'd0;
                    resp_valid_d = 1'b1;
                    // ack takes priority over a coincident timeout
                    resp_err_d   = ~wb_ack;
                    resp_rdata_d = wb_ack ? load_ext : 32'd0;
                end else begin
                    cnt_d = cnt_next;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            cnt_q        <= 16'd0;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            sel_q        <= 4'd0;
            adr_q        <= 32'd0;
            dat_q        <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            cnt_q        <= cnt_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign req_ready  = (state_q == IDLE) && !rst;
    assign wb_cyc     = cyc_q;
    assign wb_stb     = cyc_q;
    assign wb_we      = we_q;
    assign wb_sel     = sel_q;
    assign wb_adr     = adr_q;
    assign wb_dat_o   = dat_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule
